// File: rtl/four_nand_pkg.sv
// Shared defaults and lane-wise reset constants for the four_nand block.
package four_nand_pkg;

  localparam int DEF_WIDTH = 1;
  localparam int DEF_CNT_W = 16;

  // Per-lane reset values, replicated across WIDTH by the users.
  localparam logic E_RST = 1'b1;
  localparam logic F_RST = 1'b1;
  localparam logic G_RST = 1'b0;

endpackage

// File: rtl/nand2_cell.sv
// WIDTH-wide bitwise 2-input NAND; purely combinational.
module nand2_cell #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = ~(a & b);

endmodule

// File: rtl/four_nand.sv
// Registered two-level NAND tree (g = (a&b)|(c&d)) with a saturating
// counter of 0->1 transitions on registered g[0].
module four_nand
  import four_nand_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             in_valid,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic             out_valid,
  output logic [CNT_W-1:0] g_rise_cnt
);

  // Handshake: no ready; every cycle with in_valid=1 and rst=0 is accepted,
  // and out_valid pulses on the cycle after each accepted sample.

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] e_next;
  logic [WIDTH-1:0] f_next;
  logic [WIDTH-1:0] g_next;
  logic             g_rise;

  nand2_cell #(.WIDTH(WIDTH)) u_nand_e (.a(a),      .b(b),      .y(e_next));
  nand2_cell #(.WIDTH(WIDTH)) u_nand_f (.a(c),      .b(d),      .y(f_next));
  nand2_cell #(.WIDTH(WIDTH)) u_nand_g (.a(e_next), .b(f_next), .y(g_next));

  // g only moves on a load, so a rise is a load that takes lane 0 from 0 to 1.
  assign g_rise = in_valid & ~g[0] & g_next[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      e          <= {WIDTH{E_RST}};
      f          <= {WIDTH{F_RST}};
      g          <= {WIDTH{G_RST}};
      out_valid  <= 1'b0;
      g_rise_cnt <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        e <= e_next;
        f <= f_next;
        g <= g_next;
      end
      if (g_rise && (g_rise_cnt != CNT_MAX)) begin
        g_rise_cnt <= g_rise_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_four_nand.sv
// Self-checking bench for four_nand: a 4-lane instance plus a 1-lane instance
// with a 3-bit counter so saturation is reachable in a few cycles.
module tb_four_nand;

  localparam int W   = 4;
  localparam int CW  = 16;
  localparam int SCW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0]   a = '0, b = '0, c = '0, d = '0;
  logic           in_valid = 1'b0;
  logic [W-1:0]   e, f, g;
  logic           out_valid;
  logic [CW-1:0]  g_rise_cnt;

  logic [0:0]     se, sf, sg;
  logic           s_out_valid;
  logic [SCW-1:0] s_cnt;

  four_nand #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .in_valid(in_valid),
    .e(e), .f(f), .g(g), .out_valid(out_valid), .g_rise_cnt(g_rise_cnt)
  );

  four_nand #(.WIDTH(1), .CNT_W(SCW)) dut_sat (
    .clk(clk), .rst(rst), .a(a[0:0]), .b(b[0:0]), .c(c[0:0]), .d(d[0:0]),
    .in_valid(in_valid), .e(se), .f(sf), .g(sg), .out_valid(s_out_valid),
    .g_rise_cnt(s_cnt)
  );

  // ---------------- reference model + scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] m_e = '1, m_f = '1, m_g = '0;
  logic         m_ov = 1'b0;
  int           m_cnt = 0, m_scnt = 0;
  logic [31:0]  exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Evaluates the block's rules at a rising edge from the inputs on the pins.
  task automatic model_edge();
    logic [W-1:0] new_g;
    if (rst) begin
      m_e = '1; m_f = '1; m_g = '0; m_ov = 1'b0; m_cnt = 0; m_scnt = 0;
    end else if (in_valid) begin
      new_g = (a & b) | (c & d);
      if (!m_g[0] && new_g[0]) begin
        if (m_cnt  < (2**CW)  - 1) m_cnt++;
        if (m_scnt < (2**SCW) - 1) m_scnt++;
      end
      m_e = ~(a & b); m_f = ~(c & d); m_g = new_g; m_ov = 1'b1;
    end else begin
      m_ov = 1'b0;
    end
    exp_q.push_back({m_scnt[2:0], m_cnt[15:0], m_ov, m_g, m_f, m_e});
  endtask

  task automatic scoreboard_check();
    logic [31:0] x;
    x = exp_q.pop_front();
    check("e",         32'(e),          32'(x[3:0]));
    check("f",         32'(f),          32'(x[7:4]));
    check("g",         32'(g),          32'(x[11:8]));
    check("out_valid", 32'(out_valid),  32'(x[12]));
    check("rise_cnt",  32'(g_rise_cnt), 32'(x[28:13]));
    check("sat_g",     32'(sg),         32'(x[8]));
    check("sat_cnt",   32'(s_cnt),      32'(x[31:29]));
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic v,
                      input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic [W-1:0] tc, input logic [W-1:0] td);
    @(negedge clk);
    rst = r; in_valid = v; a = ta; b = tb; c = tc; d = td;
    @(posedge clk);
    model_edge();
    #1;
    scoreboard_check();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [3:0] vv;
    logic [W-1:0] ra, rb, rc, rd;

    // Reset with garbage valid input: must be discarded.
    step(1'b1, 1'b1, '1, '1, '1, '1);
    step(1'b1, 1'b0, '0, '0, '0, '0);
    check("rst_e", 32'(e), 32'hF);
    check("rst_f", 32'(f), 32'hF);
    check("rst_g", 32'(g), 32'h0);
    check("rst_ov", 32'(out_valid), 32'h0);
    check("rst_cnt", 32'(g_rise_cnt), 32'h0);

    // First load of all zeros.
    step(1'b0, 1'b1, '0, '0, '0, '0);
    check("zero_e", 32'(e), 32'hF);
    check("zero_g", 32'(g), 32'h0);
    check("zero_ov", 32'(out_valid), 32'h1);

    // Exhaustive lane-0 sweep, d fastest; other lanes random.
    for (int v = 0; v < 16; v++) begin
      vv = 4'(v);
      ra = W'($urandom); rb = W'($urandom); rc = W'($urandom); rd = W'($urandom);
      ra[0] = vv[3]; rb[0] = vv[2]; rc[0] = vv[1]; rd[0] = vv[0];
      step(1'b0, 1'b1, ra, rb, rc, rd);
      if (v == 12) begin
        check("spot1100_efg", {29'd0, e[0], f[0], g[0]}, 32'b011);
      end
      if (v == 15) begin
        check("spot1111_efg", {29'd0, e[0], f[0], g[0]}, 32'b001);
      end
    end

    // Load all ones, then hold with inputs wiggling.
    step(1'b0, 1'b1, '1, '1, '1, '1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    end
    check("hold_e", 32'(e), 32'h0);
    check("hold_f", 32'(f), 32'h0);
    check("hold_g", 32'(g), 32'hF);
    check("hold_ov", 32'(out_valid), 32'h0);

    // Lane-wise pattern on all four lanes.
    step(1'b0, 1'b1, 4'b1100, 4'b1010, 4'b0000, 4'b1111);
    check("w4_e", 32'(e), 32'h7);
    check("w4_f", 32'(f), 32'hF);
    check("w4_g", 32'(g), 32'h8);

    // Rise counting from reset: 3 periods, then 7 more to saturate dut_sat.
    step(1'b1, 1'b0, '0, '0, '0, '0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, '0, '0, '0, '0);
      step(1'b0, 1'b1, '1, '1, '0, '0);
      if (i == 2) check("rise3", 32'(g_rise_cnt), 32'd3);
    end
    check("rise10", 32'(g_rise_cnt), 32'd10);
    check("sat_full", 32'(s_cnt), 32'd7);
    step(1'b0, 1'b1, '0, '0, '0, '0);
    step(1'b0, 1'b1, '0, '0, '1, '1);
    check("sat_hold", 32'(s_cnt), 32'd7);

    // Reset mid-stream with valid high, then first post-reset load.
    step(1'b0, 1'b1, 4'h3, 4'h5, 4'h9, 4'h6);
    step(1'b1, 1'b1, '1, '1, '1, '1);
    check("midrst_g", 32'(g), 32'h0);
    check("midrst_cnt", 32'(g_rise_cnt), 32'h0);
    step(1'b0, 1'b1, 4'hF, 4'h1, 4'h0, 4'h0);
    check("postrst_g", 32'(g), 32'h1);
    check("postrst_cnt", 32'(g_rise_cnt), 32'h1);

    // Randomised run, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
           W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end of sequence");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/four_nand.md
FOUR_NAND -- requirements
Module: four_nand

Interface
REQ-001 Parameter WIDTH, default 1: number of independent bit lanes per operand.
REQ-002 Parameter CNT_W, default 16: width of the rise-event counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 a  input  WIDTH  operand A, lane-wise.
REQ-006 b  input  WIDTH  operand B, lane-wise.
REQ-007 c  input  WIDTH  operand C, lane-wise.
REQ-008 d  input  WIDTH  operand D, lane-wise.
REQ-009 in_valid  input  1  qualifies a/b/c/d for capture this cycle.
REQ-010 e  output  WIDTH  registered NAND(a,b).
REQ-011 f  output  WIDTH  registered NAND(c,d).
REQ-012 g  output  WIDTH  registered NAND(e_next,f_next), equal to (a&b)|(c&d).
REQ-013 out_valid  output  1  high for one cycle after each accepted input.
REQ-014 g_rise_cnt  output  CNT_W  saturating count of 0->1 transitions of registered g[0].

Function
REQ-015 Per lane i: e_next[i] = ~(a[i]&b[i]), f_next[i] = ~(c[i]&d[i]), g_next[i] = ~(e_next[i]&f_next[i]).
REQ-016 Latency: exactly 1 cycle; e, f, g all come from the same input sample and update on the same edge.
REQ-017 When in_valid=1, e/f/g load e_next/f_next/g_next on the edge.
REQ-018 When in_valid=0, e/f/g hold their previous values.
REQ-019 out_valid is the registered copy of in_valid, so it is high exactly when e/f/g were loaded on the preceding edge.
REQ-020 No backpressure: every in_valid=1 cycle is accepted.
REQ-021 Lanes are fully independent; no cross-lane logic except g_rise_cnt, which observes lane 0 only.
REQ-022 g_rise_cnt increments by 1 on an edge where registered g[0] changes from 0 to 1.
REQ-023 g_rise_cnt does not change on holds, 1->0 transitions, or 1->1 reloads.
REQ-024 g_rise_cnt saturates at all-ones (16'hFFFF by default) and never wraps.
REQ-025 No combinational path from any input to any output.

Reset
REQ-026 While rst=1 at a rising edge: e = all-ones, f = all-ones, g = all-zeros, out_valid = 0, g_rise_cnt = 0. These values are consistent with a=b=c=d=0.
REQ-027 rst overrides in_valid; input presented during reset is discarded.
REQ-028 Reset mid-stream applies immediately at that edge; the first accepted input after rst falls is the first in_valid=1 cycle with rst=0.
REQ-029 A g[0] 0->1 change on the first post-reset load counts as a rise.

Structure
REQ-030 Shared package four_nand_pkg holds the WIDTH and CNT_W defaults.
REQ-031 four_nand_pkg holds the reset constants E_RST (ones), F_RST (ones) and G_RST (zeros).
REQ-032 One sub-module, nand2_cell (WIDTH-parameterised 2-input bitwise NAND), instantiated three times for e_next, f_next and g_next.
REQ-033 Output registers, out_valid register and the saturating counter reside in four_nand.

Verification
REQ-034 Reset, then a=0 b=0 c=0 d=0 with in_valid=1 -> next edge: e=1 f=1 g=0 out_valid=1 g_rise_cnt=0.
REQ-035 Exhaustive 16-vector sweep (WIDTH=1), d toggling fastest and a slowest, one vector per cycle -> each edge matches REQ-015. Spot checks: a=1 b=1 c=0 d=0 gives e=0 f=1 g=1; all ones gives e=0 f=0 g=1.
REQ-036 Load all-ones, then hold in_valid=0 for 5 cycles with inputs changing -> e/f/g frozen at 0/0/1, out_valid=0.
REQ-037 Alternate g between 0 and 1 for 3 periods starting from reset -> g_rise_cnt=3. Preload near saturation (force 16'hFFFE, CNT_W=16) plus 3 rises -> g_rise_cnt=16'hFFFF.
REQ-038 Assert rst for 1 cycle mid-sweep with in_valid=1 -> that edge gives the reset values; inputs from that cycle are ignored; the next valid input is loaded normally.
REQ-039 WIDTH=4: a=4'b1100 b=4'b1010 c=4'b0000 d=4'b1111 -> e=4'b0111 f=4'b1111 g=4'b1000.
